gen1_scrambler_ctrl: RTL and testbench

- Sequencing controller placed directly upstream of the Gen1 scrambler datapath.
- Accepts a byte-lane stream of 32-bit symbol words with K flags under a valid/ready handshake.
- Tracks ordered-set framing (COM, SKP, TS1/TS2, EIOS) per byte lane and produces the per-byte training_sequence mask, the scramble enable and an LFSR re-seed request.
- Forwards data, K flags and length through one registered pipeline stage, so they stay aligned with the generated controls.

---
 rtl/gen1_scrambler_ctrl_if.sv | 47 ++++
 rtl/gen1_scrambler_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_gen1_scrambler_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen1_scrambler_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gen1_scrambler_ctrl_if
// Description : Stream interface of the Gen1 scrambler sequencing controller.
//               Carries the input symbol-word handshake, the registered output
//               word with its scrambler controls, and the length-error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface gen1_scrambler_ctrl_if;
  // Input word side
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [3:0]  in_datak_i;
  logic [1:0]  in_len_i;
  logic        disable_scrambling_i;
  // Output word side
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_datak_o;
  logic [1:0]  out_len_o;
  logic        scramble_enable_o;
  logic [3:0]  training_sequence_o;
  logic        lfsr_seed_o;
  logic [1:0]  seed_lane_o;
  logic        err_len_o;

  // Symbol source / sink attached around the controller
  modport master (
    output in_valid_i, in_data_i, in_datak_i, in_len_i, disable_scrambling_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_datak_o, out_len_o,
    input  scramble_enable_o, training_sequence_o, lfsr_seed_o, seed_lane_o,
    input  err_len_o
  );

  // The controller itself
  modport slave (
    input  in_valid_i, in_data_i, in_datak_i, in_len_i, disable_scrambling_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_datak_o, out_len_o,
    output scramble_enable_o, training_sequence_o, lfsr_seed_o, seed_lane_o,
    output err_len_o
  );
endinterface
`default_nettype wire

// File: rtl/gen1_scrambler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gen1_scrambler_ctrl
// Description : Sequencing controller ahead of the Gen1 scrambler. Tracks
//               ordered-set framing (COM/SKP/TS1/TS2/EIOS) across the active
//               byte lanes of each word and registers the per-byte
//               training-sequence mask, scramble enable and LFSR re-seed
//               request alongside a one-stage copy of the word.
//               Optional statistics counters: define GEN1_SCR_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gen1_scrambler_ctrl #(
  parameter int         OS_LEN  = 16,
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [7:0] SKP_SYM = 8'h1C,
  parameter logic [7:0] IDL_SYM = 8'h7C
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gen1_scrambler_ctrl_if.slave  bus
`ifdef GEN1_SCR_CTRL_STATS_EN
  ,
  output logic [15:0]           ts_count_o,
  output logic [15:0]           skp_count_o
`endif
);

  localparam int c_CNT_W = (OS_LEN > 1) ? $clog2(OS_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(OS_LEN - 1);
  // Header symbol is index 1, so the first TS body byte is index 2
  localparam logic [c_CNT_W-1:0] c_CNT_START = c_CNT_W'(2);

  localparam logic [2:0] c_ST_DATA   = 3'd0;
  localparam logic [2:0] c_ST_OS_HDR = 3'd1;
  localparam logic [2:0] c_ST_SKP    = 3'd2;
  localparam logic [2:0] c_ST_EIOS   = 3'd3;
  localparam logic [2:0] c_ST_TS     = 3'd4;

  logic [2:0]         state_q, state_d, lane_state;
  logic [c_CNT_W-1:0] cnt_q, cnt_d, lane_cnt;
  logic [3:0]         lane_act, lane_mask;
  logic               lane_seed;
  logic [1:0]         lane_seed_idx;
  logic [7:0]         sym;
  logic               sym_k;
  logic               in_ready, xfer, len_ok, load;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_datak_q, out_datak_d;
  logic [1:0]  out_len_q, out_len_d;
  logic        scr_en_q, scr_en_d;
  logic [3:0]  ts_mask_q, ts_mask_d;
  logic        seed_q, seed_d;
  logic [1:0]  seed_lane_q, seed_lane_d;
  logic        err_len_q, err_len_d;
`ifdef GEN1_SCR_CTRL_STATS_EN
  logic [2:0]  ts_done_n, skp_ent_n;
  logic [15:0] ts_cnt_q, ts_cnt_d, skp_cnt_q, skp_cnt_d;
  logic [16:0] ts_sum, skp_sum;
`endif

  // A new word is accepted whenever the output slot is empty or draining
  assign in_ready = !out_valid_q | bus.out_ready_i;
  assign xfer     = bus.in_valid_i & in_ready;
  assign len_ok   = (bus.in_len_i != 2'b11);
  assign load     = xfer & len_ok;

  // Decode in_len into the set of lanes that carry symbols
  always_comb begin
    case (bus.in_len_i)
      2'b00:   lane_act = 4'b0001;
      2'b01:   lane_act = 4'b0011;
      2'b10:   lane_act = 4'b1111;
      default: lane_act = 4'b0000;
    endcase
  end

  // Next-state: walk the active lanes oldest-first through the framing FSM
  always_comb begin
    lane_state    = state_q;
    lane_cnt      = cnt_q;
    lane_mask     = '0;
    lane_seed     = 1'b0;
    lane_seed_idx = 2'd0;
    sym           = 8'h00;
    sym_k         = 1'b0;
`ifdef GEN1_SCR_CTRL_STATS_EN
    ts_done_n     = 3'd0;
    skp_ent_n     = 3'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (lane_act[i]) begin
        sym   = bus.in_data_i[8*i +: 8];
        sym_k = bus.in_datak_i[i];
        if (sym_k && sym == COM_SYM) begin
          // A comma always opens a fresh ordered set, whatever came before
          lane_state    = c_ST_OS_HDR;
          lane_cnt      = '0;
          lane_mask[i]  = 1'b1;
          lane_seed     = 1'b1;
          lane_seed_idx = 2'(i);
        end else begin
          case (lane_state)
            c_ST_OS_HDR: begin
              lane_mask[i] = 1'b1;
              if (sym_k && sym == SKP_SYM) begin
                lane_state = c_ST_SKP;
`ifdef GEN1_SCR_CTRL_STATS_EN
                skp_ent_n  = skp_ent_n + 3'd1;
`endif
              end else if (sym_k && sym == IDL_SYM) begin
                lane_state = c_ST_EIOS;
              end else begin
                lane_state = c_ST_TS;
                lane_cnt   = c_CNT_START;
              end
            end
            c_ST_SKP: begin
              if (sym_k && sym == SKP_SYM) lane_mask[i] = 1'b1;
              else                         lane_state   = c_ST_DATA;
            end
            c_ST_EIOS: begin
              if (sym_k && sym == IDL_SYM) lane_mask[i] = 1'b1;
              else                         lane_state   = c_ST_DATA;
            end
            c_ST_TS: begin
              lane_mask[i] = 1'b1;
              if (lane_cnt == c_CNT_LAST) begin
                lane_state = c_ST_DATA;
                lane_cnt   = '0;
`ifdef GEN1_SCR_CTRL_STATS_EN
                ts_done_n  = ts_done_n + 3'd1;
`endif
              end else begin
                lane_cnt = lane_cnt + c_CNT_W'(1);
              end
            end
            default: lane_state = c_ST_DATA;
          endcase
        end
      end
    end
    // Dropped and absent words leave the framing state untouched
    state_d = load ? lane_state : state_q;
    cnt_d   = load ? lane_cnt   : cnt_q;
  end

  // State register for the framing FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= c_ST_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output next-values: load on a legal transfer, otherwise hold or drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_datak_d = out_datak_q;
    out_len_d   = out_len_q;
    scr_en_d    = scr_en_q;
    ts_mask_d   = ts_mask_q;
    seed_d      = seed_q;
    seed_lane_d = seed_lane_q;
    err_len_d   = xfer & !len_ok;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data_i;
      out_datak_d = bus.in_datak_i;
      out_len_d   = bus.in_len_i;
      scr_en_d    = !bus.disable_scrambling_i;
      ts_mask_d   = lane_mask;
      seed_d      = lane_seed;
      seed_lane_d = lane_seed_idx;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output pipeline registers; reset discards any pending word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_datak_q <= '0;
      out_len_q   <= '0;
      scr_en_q    <= 1'b1;
      ts_mask_q   <= '0;
      seed_q      <= 1'b0;
      seed_lane_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_datak_q <= out_datak_d;
      out_len_q   <= out_len_d;
      scr_en_q    <= scr_en_d;
      ts_mask_q   <= ts_mask_d;
      seed_q      <= seed_d;
      seed_lane_q <= seed_lane_d;
      err_len_q   <= err_len_d;
    end
  end

`ifdef GEN1_SCR_CTRL_STATS_EN
  // Saturating ordered-set statistics, advanced only by accepted words
  always_comb begin
    ts_sum    = {1'b0, ts_cnt_q}  + 17'(ts_done_n);
    skp_sum   = {1'b0, skp_cnt_q} + 17'(skp_ent_n);
    ts_cnt_d  = ts_cnt_q;
    skp_cnt_d = skp_cnt_q;
    if (load) begin
      ts_cnt_d  = ts_sum[16]  ? 16'hFFFF : ts_sum[15:0];
      skp_cnt_d = skp_sum[16] ? 16'hFFFF : skp_sum[15:0];
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt_q  <= '0;
      skp_cnt_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      skp_cnt_q <= skp_cnt_d;
    end
  end

  assign ts_count_o  = ts_cnt_q;
  assign skp_count_o = skp_cnt_q;
`endif

  assign bus.in_ready_o          = in_ready;
  assign bus.out_valid_o         = out_valid_q;
  assign bus.out_data_o          = out_data_q;
  assign bus.out_datak_o         = out_datak_q;
  assign bus.out_len_o           = out_len_q;
  assign bus.scramble_enable_o   = scr_en_q;
  assign bus.training_sequence_o = ts_mask_q;
  assign bus.lfsr_seed_o         = seed_q;
  assign bus.seed_lane_o         = seed_lane_q;
  assign bus.err_len_o           = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_gen1_scrambler_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen1_scrambler_ctrl
// Description : Self-checking bench for gen1_scrambler_ctrl. A history-based
//               ordered-set model predicts mask / seed for every word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen1_scrambler_ctrl;
  localparam int OS_LEN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gen1_scrambler_ctrl_if bus_if ();
`ifdef GEN1_SCR_CTRL_STATS_EN
  logic [15:0] ts_count, skp_count;
`endif

  gen1_scrambler_ctrl #(
    .OS_LEN (OS_LEN), .COM_SYM(8'hBC), .SKP_SYM(8'h1C), .IDL_SYM(8'h7C)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
`ifdef GEN1_SCR_CTRL_STATS_EN
    , .ts_count_o (ts_count), .skp_count_o(skp_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: symbols seen since the last comma of an open ordered set
  bit         os_open;
  logic [7:0] hist_sym[$];
  bit         hist_k[$];
  logic [3:0] exp_mask;
  logic       exp_seed;
  logic [1:0] exp_lane;

  task automatic model_reset();
    os_open = 1'b0;
    hist_sym.delete();
    hist_k.delete();
  endtask

  task automatic model_word(input logic [31:0] d, input logic [3:0] k, input logic [1:0] len);
    int n, pos;
    logic [7:0] s;
    bit kk;
    exp_mask = 4'h0; exp_seed = 1'b0; exp_lane = 2'd0;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : (len == 2'b10) ? 4 : 0;
    for (int i = 0; i < n; i++) begin
      s = d[8*i +: 8];
      kk = k[i];
      if (kk && s == 8'hBC) begin
        hist_sym.delete(); hist_k.delete();
        hist_sym.push_back(s); hist_k.push_back(kk);
        os_open = 1'b1; exp_mask[i] = 1'b1; exp_seed = 1'b1; exp_lane = 2'(i);
      end else if (os_open) begin
        pos = hist_sym.size();
        if (pos == 1) begin
          exp_mask[i] = 1'b1;
          hist_sym.push_back(s); hist_k.push_back(kk);
        end else if (hist_k[1] && (hist_sym[1] == 8'h1C || hist_sym[1] == 8'h7C)) begin
          // SKP / EIOS bodies repeat their header symbol
          if (kk && s == hist_sym[1]) exp_mask[i] = 1'b1;
          else os_open = 1'b0;
        end else begin
          exp_mask[i] = 1'b1;
          if (pos == OS_LEN - 1) os_open = 1'b0;
          else begin hist_sym.push_back(s); hist_k.push_back(kk); end
        end
      end
    end
  endtask

  // Snapshot of all registered outputs; seed_lane only meaningful with a seed
  function automatic logic [47:0] snap();
    return {bus_if.out_valid_o, bus_if.out_data_o, bus_if.out_datak_o, bus_if.out_len_o,
            bus_if.training_sequence_o, bus_if.lfsr_seed_o,
            bus_if.seed_lane_o & {2{bus_if.lfsr_seed_o}},
            bus_if.scramble_enable_o, bus_if.err_len_o};
  endfunction

  // Present one word for one cycle and sample #1 after the capturing edge
  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic [1:0] len, input logic dis);
    @(negedge clk);
    bus_if.in_valid_i = 1'b1;
    bus_if.in_data_i = d;
    bus_if.in_datak_i = k;
    bus_if.in_len_i = len;
    bus_if.disable_scrambling_i = dis;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] exp_v;
    rst = 1'b1;
    bus_if.in_valid_i = 1'b0; bus_if.in_data_i = '0; bus_if.in_datak_i = '0;
    bus_if.in_len_i = '0; bus_if.disable_scrambling_i = 1'b0; bus_if.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = {1'b0, 32'h0, 4'h0, 2'h0, 4'h0, 1'b0, 2'h0, 1'b1, 1'b0};
    n_cmp++;
    if (snap() !== exp_v) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", snap(), exp_v);
    end
    n_cmp++;
    if (bus_if.in_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_data();
    logic [47:0] exp_v;
    logic [31:0] d;
    for (int j = 0; j < 5; j++) begin
      d = (j < 4) ? 32'h03020100 : 32'hBCBCBCBC;  // last word: non-K commas
      drive(d, 4'h0, 2'b10, 1'b0);
      model_word(d, 4'h0, 2'b10);
      exp_v = {1'b1, d, 4'h0, 2'b10, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0};
      n_cmp++;
      if (snap() !== exp_v || exp_mask !== 4'h0) begin
        n_bad++; $display("FAIL data_word%0d: got %h want %h", j, snap(), exp_v);
      end
    end
    idle();
    @(posedge clk); #1;
    n_cmp++;
    if (bus_if.out_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL data_drain: out_valid got %b want 0", bus_if.out_valid_o);
    end
  endtask

  task automatic test_ts1();
    logic [31:0] d;
    logic [3:0] k;
    logic [3:0] req_mask[5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    logic [47:0] exp_v;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) begin d = 32'h10F7F7BC; k = 4'b0011; end
      else if (j == 4) begin d = 32'h03020100; k = 4'h0; end
      else begin d = $urandom; k = 4'h0; end
      drive(d, k, 2'b10, 1'b0);
      model_word(d, k, 2'b10);
      exp_v = {1'b1, d, k, 2'b10, exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
      n_cmp++;
      if (snap() !== exp_v || bus_if.training_sequence_o !== req_mask[j]
          || bus_if.lfsr_seed_o !== (j == 0)) begin
        n_bad++; $display("FAIL ts1_word%0d: got %h want %h (mask want %h)", j, snap(), exp_v, req_mask[j]);
      end
    end
    idle();
  endtask

  task automatic test_skp();
    logic [31:0] d[2] = '{32'h1C1C1CBC, 32'h44332211};
    logic [3:0] k[2] = '{4'hF, 4'h0};
    logic [3:0] req_mask[2] = '{4'hF, 4'h0};
    logic [47:0] exp_v;
    for (int j = 0; j < 2; j++) begin
      drive(d[j], k[j], 2'b10, 1'b0);
      model_word(d[j], k[j], 2'b10);
      exp_v = {1'b1, d[j], k[j], 2'b10, exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
      n_cmp++;
      if (snap() !== exp_v || bus_if.training_sequence_o !== req_mask[j]) begin
        n_bad++; $display("FAIL skp_word%0d: got %h want %h", j, snap(), exp_v);
      end
    end
    idle();
  endtask

  task automatic test_partial();
    logic [31:0] d[2];
    logic [3:0] k[2] = '{4'b0011, 4'b0001};
    logic [1:0] len[2] = '{2'b01, 2'b00};
    logic [3:0] req_mask[2] = '{4'b0011, 4'b0001};
    logic [47:0] exp_v;
    d[0] = {$urandom_range(0, 65535) & 32'hFFFF, 16'h1CBC} ;
    d[1] = {24'($urandom), 8'h1C};
    for (int j = 0; j < 2; j++) begin
      drive(d[j], k[j], len[j], 1'b0);
      model_word(d[j], k[j], len[j]);
      exp_v = {1'b1, d[j], k[j], len[j], exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
      n_cmp++;
      if (snap() !== exp_v || bus_if.training_sequence_o !== req_mask[j]) begin
        n_bad++; $display("FAIL partial_word%0d: got %h want %h", j, snap(), exp_v);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [47:0] exp_a, exp_b;
    @(negedge clk);
    bus_if.out_ready_i = 1'b0;
    bus_if.in_valid_i = 1'b1; bus_if.in_data_i = 32'h1C1C1CBC;
    bus_if.in_datak_i = 4'hF; bus_if.in_len_i = 2'b10; bus_if.disable_scrambling_i = 1'b1;
    @(posedge clk); #1;
    model_word(32'h1C1C1CBC, 4'hF, 2'b10);
    exp_a = {1'b1, 32'h1C1C1CBC, 4'hF, 2'b10, exp_mask, exp_seed, exp_lane, 1'b0, 1'b0};
    n_cmp++;
    if (snap() !== exp_a) begin
      n_bad++; $display("FAIL bp_first: got %h want %h", snap(), exp_a);
    end
    @(negedge clk);
    bus_if.in_data_i = 32'h11111C1C; bus_if.in_datak_i = 4'b0011; bus_if.disable_scrambling_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus_if.in_ready_o !== 1'b0 || snap() !== exp_a) begin
        n_bad++; $display("FAIL bp_hold%0d: ready %b got %h want %h", c, bus_if.in_ready_o, snap(), exp_a);
      end
    end
    @(negedge clk);
    bus_if.out_ready_i = 1'b1;
    @(posedge clk); #1;
    model_word(32'h11111C1C, 4'b0011, 2'b10);
    exp_b = {1'b1, 32'h11111C1C, 4'b0011, 2'b10, exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
    n_cmp++;
    if (snap() !== exp_b) begin
      n_bad++; $display("FAIL bp_release: got %h want %h", snap(), exp_b);
    end
    idle();
  endtask

  task automatic test_len_err();
    logic [47:0] exp_v;
    logic [31:0] d;
    drive(32'h00001CBC, 4'b0011, 2'b01, 1'b0);
    model_word(32'h00001CBC, 4'b0011, 2'b01);
    drive(32'h00000000, 4'h0, 2'b11, 1'b0);
    n_cmp++;
    if (bus_if.out_valid_o !== 1'b0 || bus_if.err_len_o !== 1'b1) begin
      n_bad++; $display("FAIL len_err_pulse: valid %b err %b want valid 0 err 1",
                        bus_if.out_valid_o, bus_if.err_len_o);
    end
    d = {24'($urandom), 8'h1C};
    drive(d, 4'b0001, 2'b00, 1'b0);
    model_word(d, 4'b0001, 2'b00);
    exp_v = {1'b1, d, 4'b0001, 2'b00, exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
    n_cmp++;
    if (snap() !== exp_v || bus_if.training_sequence_o !== 4'b0001) begin
      n_bad++; $display("FAIL len_err_resume: got %h want %h", snap(), exp_v);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [47:0] exp_v;
    drive(32'h10F7F7BC, 4'b0011, 2'b10, 1'b0);
    @(negedge clk);
    bus_if.in_valid_i = 1'b0; bus_if.out_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus_if.out_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_discard: out_valid got %b want 0", bus_if.out_valid_o);
    end
    @(negedge clk);
    rst = 1'b0; bus_if.out_ready_i = 1'b1;
    model_reset();
    drive(32'hA5A5A5A5, 4'h0, 2'b10, 1'b0);
    model_word(32'hA5A5A5A5, 4'h0, 2'b10);
    exp_v = {1'b1, 32'hA5A5A5A5, 4'h0, 2'b10, exp_mask, exp_seed, exp_lane, 1'b1, 1'b0};
    n_cmp++;
    if (snap() !== exp_v) begin
      n_bad++; $display("FAIL reset_mid_data: got %h want %h", snap(), exp_v);
    end
    idle();
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] d;
    logic [3:0] k;
    logic [1:0] len;
    logic dis;
    logic [47:0] exp_v;
    int r;
    for (int j = 0; j < 300; j++) begin
      len = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      for (int b = 0; b < 4; b++) begin
        r = $urandom_range(0, 7);
        if (r < 2)       d[8*b +: 8] = 8'hBC;
        else if (r < 4)  d[8*b +: 8] = 8'h1C;
        else if (r == 4) d[8*b +: 8] = 8'h7C;
        else             d[8*b +: 8] = 8'($urandom);
        k[b] = ($urandom_range(0, 3) != 0);
      end
      dis = ($urandom_range(0, 7) == 0);
      drive(d, k, len, dis);
      if (len == 2'b11) begin
        n_cmp++;
        if (bus_if.out_valid_o !== 1'b0 || bus_if.err_len_o !== 1'b1) begin
          n_bad++; $display("FAIL rand%0d_drop: valid %b err %b want 0 1", j,
                            bus_if.out_valid_o, bus_if.err_len_o);
        end
      end else begin
        model_word(d, k, len);
        exp_v = {1'b1, d, k, len, exp_mask, exp_seed, exp_lane, ~dis, 1'b0};
        n_cmp++;
        if (snap() !== exp_v) begin
          n_bad++; $display("FAIL rand%0d_word: got %h want %h", j, snap(), exp_v);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_data();
    test_ts1();
    test_skp();
    test_partial();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
